// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: width helper and the packed status-flag layout.
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Bit positions of each flag inside a packed status word
  localparam int FIFO_FLAG_UNDERFLOW    = 0;
  localparam int FIFO_FLAG_OVERFLOW     = 1;
  localparam int FIFO_FLAG_ALMOST_EMPTY = 2;
  localparam int FIFO_FLAG_ALMOST_FULL  = 3;
  localparam int FIFO_FLAG_EMPTY        = 4;
  localparam int FIFO_FLAG_FULL         = 5;
  localparam int FIFO_NUM_FLAGS         = 6;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_ring_if.sv
// Handshake, data and status bundle between a FIFO user (master) and fifo_ring (slave).
interface fifo_ring_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int LW = fifo_pkg::clog2(DEPTH + 1);

  logic             clear;
  logic [WIDTH-1:0] d_in;
  logic             d_in_strobe;
  logic [WIDTH-1:0] q;
  logic             q_ready;
  logic             q_out_strobe;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, d_in, d_in_strobe, q_out_strobe,
    input  q, q_ready, full, empty, level,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  clear, d_in, d_in_strobe, q_out_strobe,
    output q, q_ready, full, empty, level,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ring_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_ring_mem #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // No reset: contents are only meaningful behind the pointers
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_ring.sv
// Circular-buffer FIFO with occupancy, threshold flags, sticky errors and optional fall-through.
module fifo_ring
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   fifo_ring_if.slave bus
);

   localparam int LW = clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 2) ? clog2(DEPTH) : 1;

   localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
   localparam logic [LW-1:0] L_AF    = LW'(AF_LEVEL);
   localparam logic [LW-1:0] L_AE    = LW'(AE_LEVEL);
   localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_empty;
   logic             w_full;
   logic             w_q_ready;
   logic             w_rd_ok;
   logic             w_wr_ok;
   logic             w_bypass;
   logic             w_we;
   logic             w_pop;
   logic [WIDTH-1:0] w_rdata;
   fifo_flags_t      w_flags;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == P_LAST) ? '0 : p + PW'(1);
   endfunction

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == L_DEPTH);

   generate
      if (FWFT != 0) begin : g_fwft
         // Empty FIFO forwards the incoming word so a reader sees it this cycle
         assign w_q_ready = !w_empty || bus.d_in_strobe;
         assign bus.q     = w_empty ? bus.d_in : w_rdata;
      end else begin : g_reg
         assign w_q_ready = !w_empty;
         assign bus.q     = w_rdata;
      end
   endgenerate

   assign w_rd_ok  = bus.q_out_strobe && w_q_ready;
   assign w_wr_ok  = bus.d_in_strobe && (!w_full || w_rd_ok);
   assign w_bypass = (FWFT != 0) && w_empty && w_wr_ok && w_rd_ok;
   assign w_we     = w_wr_ok && !w_bypass && !bus.clear && rst_n;
   assign w_pop    = w_rd_ok && !w_bypass;

   fifo_ring_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.d_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.clear) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_we)  r_wr_ptr <= f_next(r_wr_ptr);
         if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
         case ({w_we, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         if (bus.d_in_strobe && !w_wr_ok)    r_overflow  <= 1'b1;
         if (bus.q_out_strobe && !w_q_ready) r_underflow <= 1'b1;
      end
   end

   assign w_flags.full         = w_full;
   assign w_flags.empty        = w_empty;
   assign w_flags.almost_full  = (r_level >= L_AF);
   assign w_flags.almost_empty = (r_level <= L_AE);
   assign w_flags.overflow     = r_overflow;
   assign w_flags.underflow    = r_underflow;

   assign bus.q_ready      = w_q_ready;
   assign bus.level        = r_level;
   assign bus.full         = w_flags.full;
   assign bus.empty        = w_flags.empty;
   assign bus.almost_full  = w_flags.almost_full;
   assign bus.almost_empty = w_flags.almost_empty;
   assign bus.overflow     = w_flags.overflow;
   assign bus.underflow    = w_flags.underflow;

endmodule

// File: doc/fifo_ring.md
# fifo_ring

Parametrised circular-buffer FIFO that succeeds the shift-chain element FIFO. It is used wherever the IO881 datapath needs deeper or wider buffering than a register chain can give. Storage is a register array addressed by wrapping read/write pointers, so element count no longer costs a mux per stage. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky error flags, synchronous clear, and a selectable fall-through (bypass) or registered output mode.

## Interface
- WIDTH, 4, data bits per entry
- DEPTH, 8, entries; any value ≥ 2 (power of two not required)
- AF_LEVEL, DEPTH-1, almost_full asserted when level ≥ AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when level ≤ AE_LEVEL
- FWFT, 1, 1 = fall-through with empty bypass; 0 = output from storage only

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush
- d_in  in  WIDTH  write data
- d_in_strobe  in  1  write request
- q  out  WIDTH  head data; valid when q_ready
- q_ready  out  1  head data valid
- q_out_strobe  in  1  read request (pop head)
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- level  out  LW = clog2(DEPTH+1)  stored entry count
- almost_full  out  1  level ≥ AF_LEVEL
- almost_empty  out  1  level ≤ AE_LEVEL
- overflow  out  1  sticky; rejected write seen
- underflow  out  1  sticky; rejected read seen

## Operation
- Read accepted (rd_ok) = q_out_strobe && q_ready.
- Write accepted (wr_ok) = d_in_strobe && (!full || rd_ok).
- q_ready: FWFT=1 gives !empty || d_in_strobe. FWFT=0 gives !empty.
- q: FWFT=1 and empty gives d_in (bypass). Otherwise q = mem[rd_ptr].
- Bypass case: FWFT=1, empty, wr_ok && rd_ok. The word passes straight through. Nothing is stored. Pointers and level are unchanged.
- Otherwise:
  - wr_ok writes mem[wr_ptr] and advances wr_ptr.
  - rd_ok advances rd_ptr.
  - Pointers wrap from DEPTH-1 to 0.
  - level changes by +1 for write only, −1 for read only, and 0 when both or neither.
- Full with simultaneous write+read: both accepted, level stays DEPTH, and the write fills the slot being vacated.
- Write while full without a read: dropped, contents unchanged, overflow set.
- q_out_strobe while !q_ready: ignored, underflow set.
- Flags are combinational from level. With FWFT=1, empty stays 1 during a bypass.
- clear has priority over both strobes. It zeroes pointers, level, overflow and underflow. It is the only way, other than rst_n, to clear the sticky flags. Array contents are not cleared.

## Timing
- Reset (rst_n low, async) sets:
  - pointers = 0, level = 0
  - empty = 1, full = 0
  - almost_empty = 1 (for AE_LEVEL ≥ 0), almost_full = 0
  - overflow = 0, underflow = 0
  - q_ready = 0 with no strobe
- q is don't-care in reset except in the FWFT bypass, where q = d_in.
- Reset released mid-burst: the next edge behaves as from empty. Strobes that arrive while rst_n is low are lost and do not set error flags.
- Write-to-read latency:
  - FWFT=1: 0 cycles via bypass when empty, otherwise data is visible on q the cycle after the write edge.
  - FWFT=0: 1 cycle.
- level, full and empty update on the edge that accepts the strobe.
- Sticky flags assert on the edge after the offending strobe.
- Strobes are sampled only at rising clk. A strobe held high for N cycles performs N operations.

## Structure
- Shared package fifo_pkg holds:
  - a clog2 constant function used for level and pointer widths
  - a FIFO_FLAG_* bit-index set (full, empty, almost_full, almost_empty, overflow, underflow) for status registers that pack the flags
- Sub-module fifo_ring_mem:
  - DEPTH×WIDTH register array
  - one synchronous write port and one asynchronous read port
  - no reset on the array

## Test plan
- Reset, then write 0x1…0x8 into DEPTH=8 → level 8, full=1, almost_full=1. Reading 8 times returns 0x1…0x8 in order and ends with empty=1.
- Write to full, then 3 cycles with both strobes held and d_in 0xA, 0xB, 0xC → level stays 8, and q sequence continues 0x1, 0x2, 0x3, then 0x4 on the next read. Write/read 20 entries total to exercise pointer wrap.
- FWFT=1, empty, d_in=0x5 with both strobes → q=0x5 and q_ready=1 in the same cycle. Next cycle level=0, empty=1.
- FWFT=0, empty, write 0x7 → q_ready=0 that cycle and q_ready=1, q=0x7 the next.
- Full, write with no read → overflow=1, data unchanged. Read on empty → underflow=1. Both flags hold until a clear pulse, after which level=0 and both flags are 0.
- Assert rst_n=0 asynchronously mid-stream at level 5 → level=0 and empty=1 immediately, before the next clk edge.
